// File: rtl/recovery_seq.sv
// Recovery sequencer: on a flush it holds rename, rolls back for one cycle, then walks the
// ROB up to two entries per cycle and pulses recovery_done once the walk is complete.

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'b00
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'b01
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'b10
`endif

module recovery_seq #(
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned WALK_NUM = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_valid,
  input  logic [CNT_W-1:0] flush_walk_cnt,
  input  logic             walk_hold,
  input  logic             freelist_can_alloc,
  output logic [1:0]       rob_state,
  output logic             rob_walk0_valid,
  output logic             rob_walk1_valid,
  output logic             rename_stall,
  output logic             recovery_done,
  output logic [CNT_W-1:0] walk_remaining
);

  typedef enum logic [1:0] {
    StIdle     = `ROB_STATE_IDLE,
    StRollback = `ROB_STATE_ROLLBACK,
    StWalk     = `ROB_STATE_WALK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             walk_ok;
  logic             walk0;
  logic             walk1;
  logic [CNT_W-1:0] step;

  // Slots depend on the current cycle only, so a nested flush still sees this cycle's slots.
  assign walk_ok = (state_q == StWalk) && !walk_hold;
  assign walk0   = walk_ok && (cnt_q != '0);
  assign walk1   = walk_ok && (WALK_NUM >= 2) && (cnt_q > CNT_W'(1));
  assign step    = CNT_W'(walk0) + CNT_W'(walk1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StRollback: begin
        state_d = (cnt_q != '0) ? StWalk : StIdle;
      end
      StWalk: begin
        if (!walk_hold) begin
          cnt_d = (cnt_q > step) ? (cnt_q - step) : '0;
          if (cnt_d == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new flush overrides whatever the walk was doing.
    if (flush_valid) begin
      state_d = StRollback;
      cnt_d   = flush_walk_cnt;
    end

    done_d = (state_q != StIdle) && (state_d == StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign rob_state       = state_q;
  assign rob_walk0_valid = walk0;
  assign rob_walk1_valid = walk1;
  assign rename_stall    = (state_q != StIdle) || flush_valid || !freelist_can_alloc;
  assign recovery_done   = done_q;
  assign walk_remaining  = cnt_q;

endmodule

// File: tb/tb_recovery_seq.sv
// Directed bench for recovery_seq: expected per-cycle outputs are queued as each step is driven
// and popped for comparison at the following falling edge.

module tb_recovery_seq;

  localparam int unsigned CntW  = 7;
  localparam logic [1:0]  SIdle = 2'b00;
  localparam logic [1:0]  SRb   = 2'b01;
  localparam logic [1:0]  SWalk = 2'b10;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush_valid;
  logic [CntW-1:0] flush_walk_cnt;
  logic            walk_hold;
  logic            freelist_can_alloc;
  logic [1:0]      rob_state;
  logic            rob_walk0_valid;
  logic            rob_walk1_valid;
  logic            rename_stall;
  logic            recovery_done;
  logic [CntW-1:0] walk_remaining;

  typedef struct {
    string           tag;
    logic [1:0]      st;
    logic            w0;
    logic            w1;
    logic            stall;
    logic            done;
    logic [CntW-1:0] rem;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  recovery_seq #(
    .CNT_W   (CntW),
    .WALK_NUM(2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .flush_valid       (flush_valid),
    .flush_walk_cnt    (flush_walk_cnt),
    .walk_hold         (walk_hold),
    .freelist_can_alloc(freelist_can_alloc),
    .rob_state         (rob_state),
    .rob_walk0_valid   (rob_walk0_valid),
    .rob_walk1_valid   (rob_walk1_valid),
    .rename_stall      (rename_stall),
    .recovery_done     (recovery_done),
    .walk_remaining    (walk_remaining)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic w0,
                            input logic w1, input logic stall, input logic done,
                            input logic [CntW-1:0] rem);
    exp_t e;
    e.tag = tag; e.st = st; e.w0 = w0; e.w1 = w1; e.stall = stall; e.done = done; e.rem = rem;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".state"}, 32'(rob_state), 32'(e.st));
      check({e.tag, ".walk0"}, 32'(rob_walk0_valid), 32'(e.w0));
      check({e.tag, ".walk1"}, 32'(rob_walk1_valid), 32'(e.w1));
      check({e.tag, ".stall"}, 32'(rename_stall), 32'(e.stall));
      check({e.tag, ".done"}, 32'(recovery_done), 32'(e.done));
      check({e.tag, ".remaining"}, 32'(walk_remaining), 32'(e.rem));
      check({e.tag, ".w1_without_w0"}, 32'(rob_walk1_valid & ~rob_walk0_valid), 32'd0);
    end
  endtask

  // Drive one cycle of inputs, queue what that cycle must show, compare mid-cycle.
  task automatic step(input string tag, input logic fv, input logic [CntW-1:0] cnt,
                      input logic hold, input logic fl, input logic [1:0] st, input logic w0,
                      input logic w1, input logic stall, input logic done,
                      input logic [CntW-1:0] rem);
    flush_valid        = fv;
    flush_walk_cnt     = cnt;
    walk_hold          = hold;
    freelist_can_alloc = fl;
    expect_out(tag, st, w0, w1, stall, done, rem);
    @(negedge clock);
    check_out();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush_valid = 1'b0; flush_walk_cnt = '0; walk_hold = 1'b0;
    freelist_can_alloc = 1'b1;
    #1 reset = 1'b1;

    // Reset held: flush ignored by state, but stall still follows flush_valid.
    step("rst_a", 1, 7'd9, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("rst_b", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);
    reset = 1'b0;
    step("idle0", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);

    // cnt=5, no hold
    step("t1c0", 1, 7'd5, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t1c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd5);
    step("t1c2", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd5);
    step("t1c3", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd3);
    step("t1c4", 0, 7'd0, 0, 1, SWalk, 1, 0, 1, 0, 7'd1);
    step("t1c5", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 1, 7'd0);
    step("t1c6", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);

    // cnt=4, hold on first walk cycle
    step("t2c0", 1, 7'd4, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t2c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd4);
    step("t2c2", 0, 7'd0, 1, 1, SWalk, 0, 0, 1, 0, 7'd4);
    step("t2c3", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd4);
    step("t2c4", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd2);
    step("t2c5", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 1, 7'd0);

    // cnt=0
    step("t3c0", 1, 7'd0, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t3c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd0);
    step("t3c2", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 1, 7'd0);
    step("t3c3", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);

    // cnt=6, nested flush cnt=1 on second walk cycle
    step("t4c0", 1, 7'd6, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t4c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd6);
    step("t4c2", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd6);
    step("t4c3", 1, 7'd1, 0, 1, SWalk, 1, 1, 1, 0, 7'd4);
    step("t4c4", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd1);
    step("t4c5", 0, 7'd0, 0, 1, SWalk, 1, 0, 1, 0, 7'd1);
    step("t4c6", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 1, 7'd0);

    // flush arriving on the done cycle
    step("t5c0", 1, 7'd0, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t5c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd0);
    step("t5c2", 1, 7'd2, 0, 1, SIdle, 0, 0, 1, 1, 7'd0);
    step("t5c3", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd2);
    step("t5c4", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd2);
    step("t5c5", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 1, 7'd0);

    // freelist empty while idle
    step("t6c0", 0, 7'd0, 0, 0, SIdle, 0, 0, 1, 0, 7'd0);
    step("t6c1", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);

    // reset mid-walk at remaining=3
    step("t7c0", 1, 7'd7, 0, 1, SIdle, 0, 0, 1, 0, 7'd0);
    step("t7c1", 0, 7'd0, 0, 1, SRb,   0, 0, 1, 0, 7'd7);
    step("t7c2", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd7);
    step("t7c3", 0, 7'd0, 0, 1, SWalk, 1, 1, 1, 0, 7'd5);
    expect_out("t7c4", SWalk, 1, 1, 1, 0, 7'd3);
    @(negedge clock);
    check_out();
    #1 reset = 1'b1;
    #1;
    expect_out("t7_async", SIdle, 0, 0, 0, 0, 7'd0);
    check_out();
    @(posedge clock);
    #1;
    step("t7c5", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);
    reset = 1'b0;
    step("t7c6", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);
    step("t7c7", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);
    step("t7c8", 0, 7'd0, 0, 1, SIdle, 0, 0, 0, 0, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
